// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } pipe_state_e;

    // Plain constants for the state register, kept as raw bit patterns so the
    // state vector stays a simple logic [1:0] for older tool flows.
    localparam logic [1:0] ST_RUN      = RUN;
    localparam logic [1:0] ST_MEM_WAIT = MEM_WAIT;
    localparam logic [1:0] ST_HALT     = HALT;

    // Default parameter values.
    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;
    localparam int unsigned DEF_CNT_W          = 16;

    // Width needed to hold every value 0..timeout without wrapping.
    function automatic int unsigned wait_cnt_width(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat_cnt.sv
// Saturating up-counter with enable; sticks at all-ones instead of wrapping.
module pipe_ctrl_sat_cnt #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             at_max;

    // Next value: increment only while enabled and not yet saturated.
    always_comb begin
        at_max  = (count_q == {CNT_W{1'b1}});
        count_d = count_q;
        if (en && !at_max) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter register, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: load-use interlock, redirect flushes, data-memory wait
// handling with a timeout that parks the pipeline in HALT, plus two saturating
// performance counters (stalled cycles and flush events).
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,

    // ID-stage source operands
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,

    // EX-stage instruction
    input  logic [4:0]       ex_wR_i,
    input  logic             ex_reg_we_i,
    input  logic             ex_is_load_i,
    input  logic             ex_redirect_i,

    // MEM-stage data memory handshake
    input  logic             dmem_req_i,
    input  logic             dmem_ack_i,

    // Pipeline control
    output logic             pc_stop_o,
    output logic             if_id_stop_o,
    output logic             id_ex_stop_o,
    output logic             ex_mem_stop_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,

    // Status and performance
    output logic             halted_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_events_o
);

    localparam int unsigned     WAIT_W    = wait_cnt_width(TIMEOUT_CYCLES);
    // Wait-counter value on which a missing ack sends us to HALT.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;

    logic              mem_stall;
    logic              rs1_hit;
    logic              rs2_hit;
    logic              load_use;

    // Internal (ungated) control decisions
    logic              stop_pc;
    logic              stop_if_id;
    logic              stop_id_ex;
    logic              stop_ex_mem;
    logic              flush_if_id;
    logic              flush_id_ex;

    // Hazard detection. A load to x0 never creates a dependency.
    always_comb begin
        mem_stall = dmem_req_i & ~dmem_ack_i;
        rs1_hit   = id_rs1_used_i & (id_rs1_i == ex_wR_i);
        rs2_hit   = id_rs2_used_i & (id_rs2_i == ex_wR_i);
        load_use  = ex_is_load_i & ex_reg_we_i & (ex_wR_i != 5'd0) & (rs1_hit | rs2_hit);
    end

    // Output decode and next-state logic. The RUN priority (redirect over
    // load-use) is shared with the MEM_WAIT ack cycle, which behaves like RUN
    // without a memory stall; a redirect waiting in EX during the memory wait
    // therefore flushes only once the ack arrives.
    always_comb begin
        stop_pc     = 1'b0;
        stop_if_id  = 1'b0;
        stop_id_ex  = 1'b0;
        stop_ex_mem = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        state_d     = state_q;
        wait_d      = wait_q;

        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    stop_pc     = 1'b1;
                    stop_if_id  = 1'b1;
                    stop_id_ex  = 1'b1;
                    stop_ex_mem = 1'b1;
                    state_d     = ST_MEM_WAIT;
                    wait_d      = '0;
                end else begin
                    // Redirect squashes the younger instructions, so a
                    // coincident load-use bubble is irrelevant.
                    flush_if_id = ex_redirect_i;
                    flush_id_ex = ex_redirect_i | load_use;
                    stop_pc     = ~ex_redirect_i & load_use;
                    stop_if_id  = ~ex_redirect_i & load_use;
                end
            end

            ST_MEM_WAIT: begin
                if (!dmem_ack_i) begin
                    stop_pc     = 1'b1;
                    stop_if_id  = 1'b1;
                    stop_id_ex  = 1'b1;
                    stop_ex_mem = 1'b1;
                    if (wait_q == WAIT_LAST) begin
                        state_d = ST_HALT;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end else begin
                    // Ack wins even on the timeout cycle.
                    flush_if_id = ex_redirect_i;
                    flush_id_ex = ex_redirect_i | load_use;
                    stop_pc     = ~ex_redirect_i & load_use;
                    stop_if_id  = ~ex_redirect_i & load_use;
                    state_d     = ST_RUN;
                    wait_d      = '0;
                end
            end

            ST_HALT: begin
                // Only reset leaves HALT.
                stop_pc     = 1'b1;
                stop_if_id  = 1'b1;
                stop_id_ex  = 1'b1;
                stop_ex_mem = 1'b1;
            end

            default: begin
                // Unused encoding: fall back to RUN.
                state_d = ST_RUN;
                wait_d  = '0;
            end
        endcase
    end

    // State and wait-counter registers; reset abandons any wait at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Drive outputs; everything is held quiet while reset is asserted.
    always_comb begin
        pc_stop_o     = stop_pc     & ~rst;
        if_id_stop_o  = stop_if_id  & ~rst;
        id_ex_stop_o  = stop_id_ex  & ~rst;
        ex_mem_stop_o = stop_ex_mem & ~rst;
        if_id_flush_o = flush_if_id & ~rst;
        id_ex_flush_o = flush_id_ex & ~rst;
        halted_o      = (state_q == ST_HALT) & ~rst;
    end

    pipe_ctrl_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (pc_stop_o),
        .count (stall_cycles_o)
    );

    pipe_ctrl_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (if_id_flush_o),
        .count (flush_events_o)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed, table-driven bench for pipe_ctrl (built with a 4-cycle timeout).
module tb_pipe_ctrl;

    localparam int unsigned CNT_W = 16;

    // Output vector order: {pc, if_id, id_ex, ex_mem stops, if_id, id_ex flushes}
    localparam logic [5:0] O_NONE  = 6'b000000;
    localparam logic [5:0] O_BUB   = 6'b110001;
    localparam logic [5:0] O_FLUSH = 6'b000011;
    localparam logic [5:0] O_STALL = 6'b111100;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] wr;
        logic       we;
        logic       ld;
        logic       redir;
        logic       req;
        logic       ack;
        logic [5:0] exp;
        string      name;
    } vec_t;

    logic             clk;
    logic             rst;
    logic [4:0]       id_rs1, id_rs2, ex_wr;
    logic             id_rs1_used, id_rs2_used, ex_reg_we, ex_is_load, ex_redirect;
    logic             dmem_req, dmem_ack;
    logic             pc_stop, if_id_stop, id_ex_stop, ex_mem_stop;
    logic             if_id_flush, id_ex_flush, halted;
    logic [CNT_W-1:0] stall_cycles, flush_events;
    logic [5:0]       outs;

    int n_pass  = 0;
    int n_total = 0;

    assign outs = {pc_stop, if_id_stop, id_ex_stop, ex_mem_stop, if_id_flush, id_ex_flush};

    pipe_ctrl #(
        .TIMEOUT_CYCLES (4),
        .CNT_W          (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs1_i       (id_rs1),
        .id_rs2_i       (id_rs2),
        .id_rs1_used_i  (id_rs1_used),
        .id_rs2_used_i  (id_rs2_used),
        .ex_wR_i        (ex_wr),
        .ex_reg_we_i    (ex_reg_we),
        .ex_is_load_i   (ex_is_load),
        .ex_redirect_i  (ex_redirect),
        .dmem_req_i     (dmem_req),
        .dmem_ack_i     (dmem_ack),
        .pc_stop_o      (pc_stop),
        .if_id_stop_o   (if_id_stop),
        .id_ex_stop_o   (id_ex_stop),
        .ex_mem_stop_o  (ex_mem_stop),
        .if_id_flush_o  (if_id_flush),
        .id_ex_flush_o  (id_ex_flush),
        .halted_o       (halted),
        .stall_cycles_o (stall_cycles),
        .flush_events_o (flush_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic apply(input vec_t v);
        id_rs1      = v.rs1;
        id_rs2      = v.rs2;
        id_rs1_used = v.u1;
        id_rs2_used = v.u2;
        ex_wr       = v.wr;
        ex_reg_we   = v.we;
        ex_is_load  = v.ld;
        ex_redirect = v.redir;
        dmem_req    = v.req;
        dmem_ack    = v.ack;
    endtask

    // Drive one cycle's inputs just after the rising edge, sample at the falling edge.
    task automatic cyc(input vec_t v);
        @(posedge clk);
        #1;
        apply(v);
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                                input logic u2, input logic [4:0] wr, input logic we,
                                input logic ld, input logic redir, input logic req,
                                input logic ack, input logic [5:0] exp, input string name);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.wr = wr; v.we = we;
        v.ld = ld; v.redir = redir; v.req = req; v.ack = ack; v.exp = exp; v.name = name;
        return v;
    endfunction

    vec_t idle_v, lu_v, redir_lu_v, req_v, ack_v, req_redir_v, ack_redir_v;

    task automatic do_reset();
        rst = 1'b1;
        apply(idle_v);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    vec_t tbl[11];

    initial begin
        idle_v      = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, O_NONE,  "idle");
        lu_v        = mk(5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0, 0, O_BUB,   "lu");
        redir_lu_v  = mk(5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 1, 0, 0, O_FLUSH, "redir_lu");
        req_v       = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, O_STALL, "req");
        ack_v       = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 1, O_NONE,  "ack");
        req_redir_v = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 0, O_STALL, "req_redir");
        ack_redir_v = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 1, O_FLUSH, "ack_redir");

        tbl[0]  = idle_v;
        tbl[1]  = lu_v;
        tbl[2]  = mk(5'd0, 5'd0, 1, 0, 5'd0, 1, 1, 0, 0, 0, O_NONE,  "load_x0");
        tbl[3]  = mk(5'd5, 5'd0, 0, 0, 5'd5, 1, 1, 0, 0, 0, O_NONE,  "rs1_unused");
        tbl[4]  = mk(5'd1, 5'd7, 0, 1, 5'd7, 1, 1, 0, 0, 0, O_BUB,   "rs2_hit");
        tbl[5]  = mk(5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0, 0, 0, O_NONE,  "not_load");
        tbl[6]  = mk(5'd5, 5'd0, 1, 0, 5'd5, 0, 1, 0, 0, 0, O_NONE,  "load_no_we");
        tbl[7]  = redir_lu_v;
        tbl[8]  = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0, O_FLUSH, "redir");
        tbl[9]  = mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 1, O_NONE,  "req_acked");
        tbl[10] = mk(5'd9, 5'd0, 1, 0, 5'd9, 1, 1, 0, 1, 1, O_BUB,   "acked_lu");

        // Outputs stay quiet while reset is held, even with a memory stall pending.
        rst = 1'b1;
        apply(req_v);
        #2;
        check("rst_outs", 32'(outs), 32'(O_NONE));
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_stall_cnt", 32'(stall_cycles), 32'd0);
        check("rst_flush_cnt", 32'(flush_events), 32'd0);

        // Single-cycle decode table (all in RUN).
        do_reset();
        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i]);
            check({"tbl_", tbl[i].name}, 32'(outs), 32'(tbl[i].exp));
        end
        cyc(idle_v);
        check("tbl_stall_cnt", 32'(stall_cycles), 32'd3);
        check("tbl_flush_cnt", 32'(flush_events), 32'd2);

        // Load-use bubble lasts one cycle.
        do_reset();
        cyc(lu_v);
        check("lu_bubble", 32'(outs), 32'(O_BUB));
        cyc(idle_v);
        check("lu_after", 32'(outs), 32'(O_NONE));
        check("lu_stall_cnt", 32'(stall_cycles), 32'd1);

        // Redirect beats coincident load-use.
        do_reset();
        cyc(redir_lu_v);
        check("redir_lu", 32'(outs), 32'(O_FLUSH));
        cyc(idle_v);
        check("redir_flush_cnt", 32'(flush_events), 32'd1);
        check("redir_stall_cnt", 32'(stall_cycles), 32'd0);

        // Memory ack after three stalled cycles.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(req_v);
            check("mw_stall", 32'(outs), 32'(O_STALL));
        end
        cyc(ack_v);
        check("mw_ack_release", 32'(outs), 32'(O_NONE));
        cyc(idle_v);
        check("mw_back_run", 32'(outs), 32'(O_NONE));
        check("mw_stall_cnt", 32'(stall_cycles), 32'd3);

        // Redirect held through the wait flushes only on the ack cycle.
        do_reset();
        cyc(req_redir_v);
        check("hold_redir_run", 32'(outs), 32'(O_STALL));
        cyc(req_redir_v);
        check("hold_redir_wait", 32'(outs), 32'(O_STALL));
        cyc(ack_redir_v);
        check("hold_redir_ack", 32'(outs), 32'(O_FLUSH));
        cyc(idle_v);
        check("hold_redir_flush_cnt", 32'(flush_events), 32'd1);
        check("hold_redir_stall_cnt", 32'(stall_cycles), 32'd2);

        // Ack on the timeout cycle wins.
        do_reset();
        repeat (4) cyc(req_v);
        cyc(ack_v);
        check("ack_wins_outs", 32'(outs), 32'(O_NONE));
        cyc(idle_v);
        check("ack_wins_halted", 32'(halted), 32'd0);
        check("ack_wins_run", 32'(outs), 32'(O_NONE));

        // Reset in the middle of a wait abandons it immediately.
        do_reset();
        cyc(req_v);
        cyc(req_v);
        #2;
        rst = 1'b1;
        #1;
        check("mid_wait_rst_outs", 32'(outs), 32'(O_NONE));
        apply(idle_v);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(idle_v);
        check("mid_wait_rst_run", 32'(outs), 32'(O_NONE));
        check("mid_wait_rst_cnt", 32'(stall_cycles), 32'd0);

        // Timeout: RUN stall cycle, then four MEM_WAIT cycles, then HALT.
        do_reset();
        repeat (5) cyc(req_v);
        check("to_not_early", 32'(halted), 32'd0);
        cyc(idle_v);
        check("to_halted", 32'(halted), 32'd1);
        check("to_halt_outs", 32'(outs), 32'(O_STALL));
        check("to_stall_cnt", 32'(stall_cycles), 32'd5);

        // Stay halted long enough to saturate the stall counter.
        repeat (70000) @(posedge clk);
        @(negedge clk);
        check("sat_stall_cnt", 32'(stall_cycles), 32'h0000_FFFF);
        check("sat_halted", 32'(halted), 32'd1);
        check("sat_outs", 32'(outs), 32'(O_STALL));

        // Reset pulse out of HALT clears everything.
        #2;
        rst = 1'b1;
        #1;
        check("halt_rst_outs", 32'(outs), 32'(O_NONE));
        check("halt_rst_halted", 32'(halted), 32'd0);
        check("halt_rst_stall_cnt", 32'(stall_cycles), 32'd0);
        check("halt_rst_flush_cnt", 32'(flush_events), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(idle_v);
        check("post_halt_outs", 32'(outs), 32'(O_NONE));
        check("post_halt_halted", 32'(halted), 32'd0);
        check("post_halt_stall_cnt", 32'(stall_cycles), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
